adder3_share_ctrl: RTL and testbench

Round-robin scheduler that shares one pipelined three-operand W-bit adder among N requesters. Each requester offers an operand triple with a request/grant handshake. The controller registers the winning triple onto the shared adder's input bus and carries the requester ID down a tag pipeline matched to the adder latency. It then returns the sum tagged with that ID. It sits between the requesting processing units and the three-input adder cover in the arithmetic datapath.

---
 rtl/adder3_share_ctrl_if.sv | 36 +++
 rtl/adder3_share_ctrl.sv | 105 ++++++++++
 tb/tb_adder3_share_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder3_share_ctrl_if.sv
// Bundle between the requesting units, the shared three-operand adder and the
// round-robin controller that multiplexes them.
interface adder3_share_ctrl_if #(
    parameter int W   = 6,
    parameter int N   = 4,
    parameter int IDW = 2
);
    // Handshake: requester i offers a triple by holding req[i] high with its
    // operands stable; the triple is taken in exactly the cycle where
    // req[i] & gnt[i]. Responses have no ready: rsp_valid is a one-cycle
    // pulse per accepted triple and must be sampled when it is high.
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N*W-1:0] c_in;
    logic           hold;
    logic [N-1:0]   gnt;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_c;
    logic [W-1:0]   add_sum;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_sum;
    logic [IDW-1:0] dbg_ptr;

    modport master (
        output req, a_in, b_in, c_in, hold, add_sum,
        input  gnt, add_a, add_b, add_c, rsp_valid, rsp_id, rsp_sum, dbg_ptr
    );

    modport slave (
        input  req, a_in, b_in, c_in, hold, add_sum,
        output gnt, add_a, add_b, add_c, rsp_valid, rsp_id, rsp_sum, dbg_ptr
    );
endinterface

// File: rtl/adder3_share_ctrl.sv
// Round-robin sharing of one pipelined three-operand adder among N requesters;
// requester IDs ride a tag pipeline matched to the adder latency.
module adder3_share_ctrl #(
    parameter int W   = 6,
    parameter int N   = 4,
    parameter int LAT = 2,
    parameter int IDW = 2
) (
    input logic clk,
    input logic rst,
    adder3_share_ctrl_if.slave bus
);
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [N-1:0]   gnt_c;
    logic           win;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] idx;

    logic           v_q   [LAT+1];
    logic [IDW-1:0] tag_q [LAT+1];

    logic [W-1:0]   add_a_q;
    logic [W-1:0]   add_b_q;
    logic [W-1:0]   add_c_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [W-1:0]   rsp_sum_q;

    // Search from ptr upward with wrap; only req, hold, rst and ptr feed gnt.
    always_comb begin
        gnt_c  = '0;
        win    = 1'b0;
        win_id = '0;
        idx    = '0;
        if (!bus.hold && !rst) begin
            for (int j = 0; j < N; j++) begin
                idx = IDW'((int'(ptr) + j) % N);
                if (!win && bus.req[idx]) begin
                    win    = 1'b1;
                    win_id = idx;
                end
            end
        end
        if (win) gnt_c[win_id] = 1'b1;
    end

    assign ptr_nxt = IDW'((int'(win_id) + 1) % N);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
            add_c_q <= '0;
            v_q[0]  <= 1'b0;
            tag_q[0] <= '0;
        end else begin
            v_q[0] <= win;
            if (win) begin
                ptr      <= ptr_nxt;
                add_a_q  <= bus.a_in[int'(win_id)*W +: W];
                add_b_q  <= bus.b_in[int'(win_id)*W +: W];
                add_c_q  <= bus.c_in[int'(win_id)*W +: W];
                tag_q[0] <= win_id;
            end
        end
    end

    // Stage k is valid in the cycle the adder output for that issue is k cycles old.
    always_ff @(posedge clk) begin
        for (int k = 1; k <= LAT; k++) begin
            if (rst) begin
                v_q[k]   <= 1'b0;
                tag_q[k] <= '0;
            end else begin
                v_q[k]   <= v_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            rsp_valid_q <= v_q[LAT];
            if (v_q[LAT]) begin
                rsp_id_q  <= tag_q[LAT];
                rsp_sum_q <= bus.add_sum;
            end
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_c     = add_c_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.dbg_ptr   = ptr;
endmodule

// File: tb/tb_adder3_share_ctrl.sv
// Directed bench for adder3_share_ctrl: reference arbiter, LAT-cycle adder model
// and an expected-response queue checked on every returned sum.
module tb_adder3_share_ctrl;
  localparam int W   = 6;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;
  localparam int EW  = 16 + IDW + W;

  logic clk;
  logic rst;
  logic [15:0] cyc = '0;
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  logic [IDW-1:0] exp_ptr = '0;
  logic [W-1:0] sum_pipe [LAT];

  adder3_share_ctrl_if #(.W(W), .N(N), .IDW(IDW)) bus ();

  adder3_share_ctrl #(.W(W), .N(N), .LAT(LAT), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 16'd1;

  // shared adder model, LAT cycles from operands to sum
  always @(posedge clk) begin
    sum_pipe[0] <= W'(bus.add_a + bus.add_b + bus.add_c);
    for (int k = 1; k < LAT; k++) sum_pipe[k] <= sum_pipe[k-1];
  end
  assign bus.add_sum = sum_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [N-1:0] g;
    g = '0;
    for (int j = 0; j < N; j++) begin
      if (g == '0 && r[(int'(p) + j) % N]) g[(int'(p) + j) % N] = 1'b1;
    end
    return g;
  endfunction

  // scoreboard: check grant, pop responses, push expected on model grants
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [EW-1:0] e;
    int id;
    eg = (rst || bus.hold) ? '0 : model_gnt(bus.req, exp_ptr);
    chk("gnt", 32'(bus.gnt), 32'(eg));
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(e[W +: IDW]));
        chk("rsp_sum", 32'(bus.rsp_sum), 32'(e[W-1:0]));
        chk("rsp_cycle", 32'(cyc), 32'(e[EW-1 -: 16]));
      end
    end
    if (rst) begin
      exp_q.delete();
      exp_ptr = '0;
    end else if (eg != '0) begin
      id = 0;
      for (int i = 0; i < N; i++) if (eg[i]) id = i;
      e = {cyc + 16'(LAT + 2), IDW'(id),
           W'(bus.a_in[id*W +: W] + bus.b_in[id*W +: W] + bus.c_in[id*W +: W])};
      exp_q.push_back(e);
      exp_ptr = IDW'((id + 1) % N);
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    bus.a_in[i*W +: W] = a;
    bus.b_in[i*W +: W] = b;
    bus.c_in[i*W +: W] = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.hold = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.c_in = '0;
    tick(3);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    chk("rst_add_a", 32'(bus.add_a), 32'd0);
    chk("rst_ptr", 32'(bus.dbg_ptr), 32'd0);
    rst = 1'b0;
    tick();

    // single request, fixed latency of four cycles
    set_op(0, 6'd10, 6'd20, 6'd30);
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    chk("single_add_a", 32'(bus.add_a), 32'd10);
    tick(3);
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_id", 32'(bus.rsp_id), 32'd0);
    chk("single_sum", 32'(bus.rsp_sum), 32'd60);
    tick();
    chk("single_pulse", 32'(bus.rsp_valid), 32'd0);
    chk("single_sum_hold", 32'(bus.rsp_sum), 32'd60);

    // overflow wraps modulo 64
    set_op(2, 6'd63, 6'd63, 6'd63);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    tick(3);
    chk("ovf_id", 32'(bus.rsp_id), 32'd2);
    chk("ovf_sum", 32'(bus.rsp_sum), 32'd61);
    tick(2);

    // rotation from reset with every requester active
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i), W'(i), W'(i));
    bus.req = 4'b1111;
    tick();
    chk("rot_ptr1", 32'(bus.dbg_ptr), 32'd1);
    tick(3);
    chk("rot_first_sum", 32'(bus.rsp_sum), 32'd0);
    tick();
    chk("rot_second_sum", 32'(bus.rsp_sum), 32'd3);
    chk("rot_second_id", 32'(bus.rsp_id), 32'd1);
    tick(6);
    bus.req = '0;
    tick(6);

    // hold freezes pointer and grants
    do_reset();
    bus.req  = 4'b1010;
    bus.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_ptr", 32'(bus.dbg_ptr), 32'd0);
    end
    bus.hold = 1'b0;
    tick();
    bus.req = 4'b1000;
    chk("hold_ptr_after1", 32'(bus.dbg_ptr), 32'd2);
    tick();
    bus.req = '0;
    chk("hold_ptr_after3", 32'(bus.dbg_ptr), 32'd0);
    tick(6);

    // reset with two operations in flight
    set_op(0, 6'd1, 6'd2, 6'd3);
    set_op(1, 6'd4, 6'd5, 6'd6);
    bus.req = 4'b0011;
    tick();
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rst_flight_quiet", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    set_op(3, 6'd5, 6'd6, 6'd7);
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    tick(3);
    chk("post_rst_id", 32'(bus.rsp_id), 32'd3);
    chk("post_rst_sum", 32'(bus.rsp_sum), 32'd18);
    tick(2);

    // withdrawal: requester 1 drops before its turn
    set_op(0, 6'd7, 6'd8, 6'd9);
    bus.req = 4'b0011;
    tick();
    bus.req = '0;
    for (int k = 0; k < 6; k++) begin
      chk("withdraw_ptr", 32'(bus.dbg_ptr), 32'd1);
      tick();
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
